idex_pipe_reg: RTL and testbench



---
 rtl/idex_pipe_reg.sv | 212 +++++++++++++++++++++
 tb/tb_idex_pipe_reg.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idex_pipe_reg.sv
// ---------------------------------------------------------------------------
// idex_pipe_reg
// ID/EX pipeline register with a valid/ready handshake, a two-entry skid
// buffer (main entry M plus skid entry S), a synchronous flush for branch and
// jump squashing, and a saturating bubble counter.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   decode-side handshake; in_ready depends on state only
//   in_ctrl             control bundle {branch, jump, jumpMem, memRead,
//                       memToReg, memWrite, aluSrc, regWrt, svpc, add, sub,
//                       inc, neg}, branch is the MSB
//   in_imm, in_pc       immediate and PC payload
//   in_rd/rs1/rs2       register indices
//   flush               squash held entries and any entry offered this cycle
//   out_valid/out_ready execute-side handshake
//   out_ctrl            control bundle, zero whenever out_valid is low
//   out_imm, out_pc     payload of the main entry
//   out_rd/rs1/rs2      register indices of the main entry
//   bubble_cnt          saturating count of cycles with out_valid low
// ---------------------------------------------------------------------------
module idex_pipe_reg #(
  parameter int CTRL_W  = 13,
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 6,
  parameter int BUB_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic [DATA_W-1:0]  in_imm,
  input  logic [DATA_W-1:0]  in_pc,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic [RADDR_W-1:0] in_rs1,
  input  logic [RADDR_W-1:0] in_rs2,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [DATA_W-1:0]  out_imm,
  output logic [DATA_W-1:0]  out_pc,
  output logic [RADDR_W-1:0] out_rd,
  output logic [RADDR_W-1:0] out_rs1,
  output logic [RADDR_W-1:0] out_rs2,
  output logic [BUB_W-1:0]   bubble_cnt
);

  // Encoding is {S.valid, M.valid}, so the valid bits fall straight out of
  // the state register. 2'b10 (skid full, main empty) is unreachable.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b11
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic w_mValid;
  logic w_sValid;
  logic w_acc;
  logic w_pop;
  logic w_loadMIn;
  logic w_loadSIn;
  logic w_moveS;

  logic [CTRL_W-1:0]  r_mCtrl;
  logic [DATA_W-1:0]  r_mImm;
  logic [DATA_W-1:0]  r_mPc;
  logic [RADDR_W-1:0] r_mRd;
  logic [RADDR_W-1:0] r_mRs1;
  logic [RADDR_W-1:0] r_mRs2;

  logic [CTRL_W-1:0]  r_sCtrl;
  logic [DATA_W-1:0]  r_sImm;
  logic [DATA_W-1:0]  r_sPc;
  logic [RADDR_W-1:0] r_sRd;
  logic [RADDR_W-1:0] r_sRs1;
  logic [RADDR_W-1:0] r_sRs2;

  logic [BUB_W-1:0]   r_bubCnt;

  assign w_mValid = r_state[0];
  assign w_sValid = r_state[1];

  // in_ready looks only at registered state, so out_ready never reaches it
  // combinationally; the skid entry is what makes that safe.
  assign in_ready  = !w_sValid;
  assign out_valid = w_mValid;
  assign w_acc     = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  // Next-state and load selects. Flush overrides everything, including a
  // coincident accept; a coincident pop still completes on the execute side.
  always_comb begin
    w_nextState = r_state;
    w_loadMIn   = 1'b0;
    w_loadSIn   = 1'b0;
    w_moveS     = 1'b0;
    if (flush) begin
      w_nextState = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_acc) begin
            w_nextState = ST_ONE;
            w_loadMIn   = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_acc && w_pop) begin
            w_loadMIn = 1'b1;
          end else if (w_acc) begin
            w_nextState = ST_TWO;
            w_loadSIn   = 1'b1;
          end else if (w_pop) begin
            w_nextState = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_pop) begin
            w_nextState = ST_ONE;
            w_moveS     = 1'b1;
          end
        end
        default: w_nextState = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Entry storage. A flush only clears the control fields; stale payload is
  // harmless because out_ctrl is masked while the entry is invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mCtrl <= '0;
      r_mImm  <= '0;
      r_mPc   <= '0;
      r_mRd   <= '0;
      r_mRs1  <= '0;
      r_mRs2  <= '0;
      r_sCtrl <= '0;
      r_sImm  <= '0;
      r_sPc   <= '0;
      r_sRd   <= '0;
      r_sRs1  <= '0;
      r_sRs2  <= '0;
    end else if (flush) begin
      r_mCtrl <= '0;
      r_sCtrl <= '0;
    end else begin
      if (w_loadMIn) begin
        r_mCtrl <= in_ctrl;
        r_mImm  <= in_imm;
        r_mPc   <= in_pc;
        r_mRd   <= in_rd;
        r_mRs1  <= in_rs1;
        r_mRs2  <= in_rs2;
      end else if (w_moveS) begin
        r_mCtrl <= r_sCtrl;
        r_mImm  <= r_sImm;
        r_mPc   <= r_sPc;
        r_mRd   <= r_sRd;
        r_mRs1  <= r_sRs1;
        r_mRs2  <= r_sRs2;
      end
      if (w_loadSIn) begin
        r_sCtrl <= in_ctrl;
        r_sImm  <= in_imm;
        r_sPc   <= in_pc;
        r_sRd   <= in_rd;
        r_sRs1  <= in_rs1;
        r_sRs2  <= in_rs2;
      end else if (w_moveS) begin
        r_sCtrl <= '0;
        r_sImm  <= '0;
        r_sPc   <= '0;
        r_sRd   <= '0;
        r_sRs1  <= '0;
        r_sRs2  <= '0;
      end
    end
  end

  // Bubble counter: counts edges where the output was empty, sticks at all
  // ones instead of wrapping, and deliberately survives flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bubCnt <= '0;
    end else if (!w_mValid && (r_bubCnt != {BUB_W{1'b1}})) begin
      r_bubCnt <= r_bubCnt + 1'b1;
    end
  end

  assign out_ctrl   = w_mValid ? r_mCtrl : '0;
  assign out_imm    = r_mImm;
  assign out_pc     = r_mPc;
  assign out_rd     = r_mRd;
  assign out_rs1    = r_mRs1;
  assign out_rs2    = r_mRs2;
  assign bubble_cnt = r_bubCnt;

endmodule

// File: tb/tb_idex_pipe_reg.sv
// ---------------------------------------------------------------------------
// tb_idex_pipe_reg
// Directed bench for idex_pipe_reg. Stimulus pushes each entry it expects to
// be accepted into a queue; a monitor pops and compares whenever the DUT
// hands an entry to execute. A second instance with a 3-bit bubble counter
// shares clock and reset to exercise saturation.
// ---------------------------------------------------------------------------
module tb_idex_pipe_reg;

  localparam int CTRL_W  = 13;
  localparam int DATA_W  = 32;
  localparam int RADDR_W = 6;
  localparam int BUB_W   = 16;

  typedef struct packed {
    logic [CTRL_W-1:0]  ctrl;
    logic [DATA_W-1:0]  imm;
    logic [DATA_W-1:0]  pc;
    logic [RADDR_W-1:0] rd;
    logic [RADDR_W-1:0] rs1;
    logic [RADDR_W-1:0] rs2;
  } entry_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [CTRL_W-1:0]  in_ctrl;
  logic [DATA_W-1:0]  in_imm;
  logic [DATA_W-1:0]  in_pc;
  logic [RADDR_W-1:0] in_rd;
  logic [RADDR_W-1:0] in_rs1;
  logic [RADDR_W-1:0] in_rs2;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [CTRL_W-1:0]  out_ctrl;
  logic [DATA_W-1:0]  out_imm;
  logic [DATA_W-1:0]  out_pc;
  logic [RADDR_W-1:0] out_rd;
  logic [RADDR_W-1:0] out_rs1;
  logic [RADDR_W-1:0] out_rs2;
  logic [BUB_W-1:0]   bubble_cnt;

  logic               satInReady;
  logic               satOutValid;
  logic [CTRL_W-1:0]  satOutCtrl;
  logic [DATA_W-1:0]  satOutImm;
  logic [DATA_W-1:0]  satOutPc;
  logic [RADDR_W-1:0] satOutRd;
  logic [RADDR_W-1:0] satOutRs1;
  logic [RADDR_W-1:0] satOutRs2;
  logic [2:0]         satBubble;

  entry_t expQ[$];
  entry_t monE;
  int     compared   = 0;
  int     mismatched = 0;
  logic   flushSeen  = 1'b0;

  always #5 clk = ~clk;

  idex_pipe_reg #(
    .CTRL_W(CTRL_W), .DATA_W(DATA_W), .RADDR_W(RADDR_W), .BUB_W(BUB_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
    .in_imm(in_imm), .in_pc(in_pc), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_imm(out_imm), .out_pc(out_pc), .out_rd(out_rd), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .bubble_cnt(bubble_cnt)
  );

  // Idle instance: never fed, so its bubble counter runs every cycle.
  idex_pipe_reg #(
    .CTRL_W(CTRL_W), .DATA_W(DATA_W), .RADDR_W(RADDR_W), .BUB_W(3)
  ) dutSat (
    .clk(clk), .rst_n(rst_n),
    .in_valid(1'b0), .in_ready(satInReady), .in_ctrl('0),
    .in_imm('0), .in_pc('0), .in_rd('0), .in_rs1('0),
    .in_rs2('0), .flush(1'b0),
    .out_valid(satOutValid), .out_ready(1'b0), .out_ctrl(satOutCtrl),
    .out_imm(satOutImm), .out_pc(satOutPc), .out_rd(satOutRd),
    .out_rs1(satOutRs1), .out_rs2(satOutRs2), .bubble_cnt(satBubble)
  );

  // One comparison; every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Payload fields derived from the PC so every entry is distinguishable.
  function automatic entry_t makeEntry(input logic [31:0] pc,
                                       input logic [CTRL_W-1:0] ctrl);
    entry_t e;
    e.ctrl = ctrl;
    e.pc   = pc;
    e.imm  = pc * 3 + 32'h11;
    e.rd   = pc[7:2];
    e.rs1  = pc[5:0] ^ 6'h2A;
    e.rs2  = ~pc[7:2];
    return e;
  endfunction

  // Drives one cycle of inputs, checks in_ready against the hand-worked
  // expectation, and queues the entry if it should be accepted.
  task automatic applyStimulus(input string name, input logic valid,
                               input logic [31:0] pc,
                               input logic [CTRL_W-1:0] ctrl,
                               input logic oReady, input logic fl,
                               input logic expInReady);
    entry_t e;
    e         = makeEntry(pc, ctrl);
    in_valid  = valid;
    in_ctrl   = e.ctrl;
    in_imm    = e.imm;
    in_pc     = e.pc;
    in_rd     = e.rd;
    in_rs1    = e.rs1;
    in_rs2    = e.rs2;
    out_ready = oReady;
    flush     = fl;
    flushSeen = fl;
    checkOutput({name, " in_ready"}, 32'(in_ready), 32'(expInReady));
    if (valid && expInReady && !fl) expQ.push_back(e);
  endtask

  // Advance past one active edge; a flush on that edge squashes everything
  // still expected (the monitor has already taken any coincident pop).
  task automatic stepEdge();
    @(posedge clk);
    #1;
    if (flushSeen) begin
      expQ.delete();
      flushSeen = 1'b0;
    end
  endtask

  // Monitor: sampled mid-cycle, a valid && ready output is consumed on the
  // coming edge, so compare it against the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected entry: got pc 0x%0h, expected none",
                   out_pc);
        end else begin
          monE = expQ.pop_front();
          checkOutput("pop pc",   out_pc,          monE.pc);
          checkOutput("pop imm",  out_imm,         monE.imm);
          checkOutput("pop ctrl", 32'(out_ctrl),   32'(monE.ctrl));
          checkOutput("pop rd",   32'(out_rd),     32'(monE.rd));
          checkOutput("pop rs1",  32'(out_rs1),    32'(monE.rs1));
          checkOutput("pop rs2",  32'(out_rs2),    32'(monE.rs2));
        end
      end
      if (!out_valid) checkOutput("bubble ctrl mask", 32'(out_ctrl), 32'h0);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset with a fully asserted control bundle offered.
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 13'h1FFF;
    in_imm    = 32'hFFFF_FFFF;
    in_pc     = 32'hFFFF_FFFF;
    in_rd     = '1;
    in_rs1    = '1;
    in_rs2    = '1;
    flush     = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("reset out_valid",  32'(out_valid),  32'h0);
    checkOutput("reset out_ctrl",   32'(out_ctrl),   32'h0);
    checkOutput("reset in_ready",   32'(in_ready),   32'h1);
    checkOutput("reset bubble_cnt", 32'(bubble_cnt), 32'h0);
    checkOutput("reset out_pc",     out_pc,          32'h0);
    checkOutput("reset sat bubble", 32'(satBubble),  32'h0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    stepEdge();
    stepEdge();
    stepEdge();
    checkOutput("idle bubble_cnt 3", 32'(bubble_cnt), 32'h3);
    checkOutput("idle sat bubble 3", 32'(satBubble),  32'h3);

    // Streaming at full rate.
    applyStimulus("stream0", 1'b1, 32'h100, 13'h0021, 1'b1, 1'b0, 1'b1);
    stepEdge();
    applyStimulus("stream1", 1'b1, 32'h104, 13'h0042, 1'b1, 1'b0, 1'b1);
    checkOutput("stream out_valid 0", 32'(out_valid), 32'h1);
    checkOutput("stream out_pc 0",    out_pc,         32'h100);
    stepEdge();
    applyStimulus("stream2", 1'b1, 32'h108, 13'h0084, 1'b1, 1'b0, 1'b1);
    checkOutput("stream out_valid 1", 32'(out_valid), 32'h1);
    checkOutput("stream out_pc 1",    out_pc,         32'h104);
    stepEdge();
    applyStimulus("stream idle", 1'b0, 32'h0, 13'h0, 1'b1, 1'b0, 1'b1);
    checkOutput("stream out_valid 2", 32'(out_valid), 32'h1);
    checkOutput("stream out_pc 2",    out_pc,         32'h108);
    stepEdge();
    checkOutput("stream drained",       32'(out_valid),  32'h0);
    checkOutput("stream bubble_cnt 4",  32'(bubble_cnt), 32'h4);

    // Back-pressure into the skid entry.
    applyStimulus("bp0", 1'b1, 32'h200, 13'h0101, 1'b0, 1'b0, 1'b1);
    stepEdge();
    applyStimulus("bp1", 1'b1, 32'h204, 13'h0202, 1'b0, 1'b0, 1'b1);
    checkOutput("bp out_pc hold 0", out_pc, 32'h200);
    stepEdge();
    applyStimulus("bp full", 1'b0, 32'h0, 13'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("bp out_pc hold 1", out_pc,         32'h200);
    checkOutput("bp out_valid",     32'(out_valid), 32'h1);
    stepEdge();
    applyStimulus("bp release", 1'b0, 32'h0, 13'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("bp out_pc hold 2", out_pc, 32'h200);
    stepEdge();
    applyStimulus("bp drain", 1'b0, 32'h0, 13'h0, 1'b1, 1'b0, 1'b1);
    checkOutput("bp skid to main", out_pc, 32'h204);
    stepEdge();
    checkOutput("bp drained",          32'(out_valid),  32'h0);
    checkOutput("bp bubble_cnt 5",     32'(bubble_cnt), 32'h5);

    // Flush in TWO with a coincident offer.
    applyStimulus("fl fill0", 1'b1, 32'h280, 13'h0123, 1'b0, 1'b0, 1'b1);
    stepEdge();
    applyStimulus("fl fill1", 1'b1, 32'h284, 13'h0456, 1'b0, 1'b0, 1'b1);
    stepEdge();
    applyStimulus("fl two", 1'b1, 32'h300, 13'h1FFF, 1'b0, 1'b1, 1'b0);
    stepEdge();
    checkOutput("fl out_valid", 32'(out_valid), 32'h0);
    checkOutput("fl out_ctrl",  32'(out_ctrl),  32'h0);
    checkOutput("fl in_ready",  32'(in_ready),  32'h1);
    applyStimulus("fl idle", 1'b0, 32'h0, 13'h0, 1'b1, 1'b0, 1'b1);
    stepEdge();
    checkOutput("fl nothing reappears", 32'(out_valid), 32'h0);

    // Flush beats an accept from EMPTY.
    applyStimulus("fl acc", 1'b1, 32'h310, 13'h0777, 1'b1, 1'b1, 1'b1);
    stepEdge();
    checkOutput("fl acc dropped 0", 32'(out_valid), 32'h0);
    applyStimulus("fl acc idle", 1'b0, 32'h0, 13'h0, 1'b1, 1'b0, 1'b1);
    stepEdge();
    checkOutput("fl acc dropped 1", 32'(out_valid), 32'h0);

    // Flush coinciding with a pop: the entry is still delivered.
    applyStimulus("fl pop fill", 1'b1, 32'h320, 13'h0999, 1'b0, 1'b0, 1'b1);
    stepEdge();
    applyStimulus("fl pop", 1'b0, 32'h0, 13'h0, 1'b1, 1'b1, 1'b1);
    stepEdge();
    checkOutput("fl pop out_valid", 32'(out_valid), 32'h0);
    checkOutput("fl pop in_ready",  32'(in_ready),  32'h1);

    // Control masking on a bubble right after a fully asserted entry.
    applyStimulus("mask fill", 1'b1, 32'h400, 13'h1FFF, 1'b0, 1'b0, 1'b1);
    stepEdge();
    checkOutput("mask held ctrl", 32'(out_ctrl), 32'h1FFF);
    applyStimulus("mask pop", 1'b0, 32'h0, 13'h0, 1'b1, 1'b0, 1'b1);
    stepEdge();
    checkOutput("mask out_valid", 32'(out_valid),   32'h0);
    checkOutput("mask out_ctrl",  32'(out_ctrl),    32'h0);
    checkOutput("mask regWrt",    32'(out_ctrl[5]), 32'h0);
    checkOutput("mask memWrite",  32'(out_ctrl[7]), 32'h0);

    // The idle 3-bit counter has seen well over 10 edges by now.
    checkOutput("sat bubble stops at 7", 32'(satBubble), 32'h7);

    // Asynchronous reset in the middle of a stream.
    applyStimulus("rst fill0", 1'b1, 32'h500, 13'h0055, 1'b0, 1'b0, 1'b1);
    stepEdge();
    applyStimulus("rst fill1", 1'b1, 32'h504, 13'h00AA, 1'b0, 1'b0, 1'b1);
    stepEdge();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async rst out_valid",  32'(out_valid),  32'h0);
    checkOutput("async rst in_ready",   32'(in_ready),   32'h1);
    checkOutput("async rst out_pc",     out_pc,          32'h0);
    checkOutput("async rst bubble_cnt", 32'(bubble_cnt), 32'h0);
    expQ.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus("post rst", 1'b1, 32'h600, 13'h0333, 1'b1, 1'b0, 1'b1);
    stepEdge();
    checkOutput("post rst out_valid", 32'(out_valid), 32'h1);
    checkOutput("post rst out_pc",    out_pc,         32'h600);
    applyStimulus("post rst idle", 1'b0, 32'h0, 13'h0, 1'b1, 1'b0, 1'b1);
    stepEdge();
    stepEdge();

    checkOutput("scoreboard drained", 32'(expQ.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
